div_tick_ctrl: RTL and testbench
================================

Name: div_tick_ctrl

Overview:
- Run-time controller for a counter-based clock-enable (tick) generator.
- Produces a one-cycle `clk_flag` pulse every DIV cycles.
- Controls:
  - start/stop sequencing;
  - a valid/ready configuration port to change the divide ratio;
  - an optional burst mode that emits exactly N ticks and then returns to idle.
- Sits between the system control logic and every block that consumes a periodic `clk_flag` enable.

Parameters:
- CNT_W, 8, width of the divide counter and of `cfg_div`.
- BURST_W, 8, width of the burst length field and burst counter.
- DEFAULT_DIV, 6, divide ratio loaded at reset. Legal range 2..2^CNT_W-1.

Ports:
- sys_clk  in  1  system clock; all logic is on its rising edge.
- sys_rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  level-sampled; begins tick generation when in IDLE.
- stop  in  1  level-sampled; aborts tick generation.
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  controller can accept a configuration.
- cfg_div  in  CNT_W  requested divide ratio.
- cfg_burst  in  BURST_W  requested burst length; 0 means continuous.
- cfg_err  out  1  one-cycle pulse: configuration rejected because `cfg_div` < 2.
- clk_flag  out  1  registered one-cycle tick.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse, coincident with the final tick of a burst.

Behaviour:
- Clock and reset: one clock, `sys_clk`. Reset `sys_rst_n` is asynchronous and active-low.
- Reset values:
  - state = IDLE, cnt = 0, div_cur = DEFAULT_DIV, burst_cur = 0, burst_cnt = 0, no pending configuration;
  - clk_flag = 0, busy = 0, done = 0, cfg_err = 0, cfg_ready = 1.
  - Reset mid-run aborts immediately; no done pulse is produced.
- States:
  - IDLE: cnt held at 0, clk_flag = 0.
    - start=1 and stop=0 at an edge → RUN, cnt = 0, burst_cnt = 0.
    - start=1 and stop=1 together: stop wins; remain in IDLE.
  - RUN: cnt counts 0..div_cur-1 and wraps to 0.
    - clk_flag is registered, high for exactly the cycle in which cnt == div_cur-1.
    - Period is exactly div_cur cycles.
    - First tick is high div_cur cycles after the start edge; e.g. DIV=6, start sampled at edge 0 → clk_flag high after edge 5.
    - stop=1 at an edge → IDLE at that edge: cnt = 0, clk_flag = 0, no done.
    - start in RUN is ignored.
- Burst mode (burst_cur > 0):
  - burst_cnt increments on each tick.
  - On the tick where burst_cnt reaches burst_cur-1 (the Nth tick), done is asserted in the same cycle as that clk_flag.
  - State returns to IDLE at the following edge.
  - burst_cur = 0 means continuous; done is never asserted.
- Configuration handshake:
  - Transfer occurs when cfg_valid && cfg_ready at an edge.
  - IDLE: cfg_ready = 1. Accepted values load div_cur and burst_cur at that edge.
  - RUN:
    - cfg_ready = 1 only when no configuration is pending.
    - An accepted configuration becomes pending; cfg_ready drops next cycle.
    - The pending configuration is applied at the wrap edge (cnt == div_cur-1 → 0) and burst_cnt is cleared.
    - Acceptance on the wrap edge itself: the new configuration is applied at the next wrap, never mid-period.
  - cfg_div < 2:
    - transfer completes (ready honoured);
    - cfg_err pulses the cycle after;
    - div_cur and burst_cur are unchanged;
    - nothing becomes pending.
  - stop or burst completion while a configuration is pending: the pending configuration is applied on the transition to IDLE.
- Arithmetic: cnt compare is unsigned CNT_W-bit; cnt never exceeds div_cur-1. burst_cnt is BURST_W-bit unsigned.

Decomposition:
- Shared package `div_tick_pkg` holds:
  - state enum (IDLE, RUN);
  - MIN_DIV = 2;
  - DEFAULT_DIV default;
  - CNT_W and BURST_W defaults.
- One natural sub-module, `div_tick_core`:
  - counter plus registered flag;
  - inputs: enable, synchronous clear, div value;
  - output: tick.
- The FSM, configuration register, pending register and burst counter stay in `div_tick_ctrl`.

Test Plan:
- Reset, then start=1 for one cycle with DIV=6 → clk_flag high at cycles 6, 12, 18 after the start edge; busy=1; done never asserted.
- In IDLE, cfg_div=3, cfg_burst=4, then start → exactly 4 ticks spaced 3 cycles apart; done coincides with the 4th tick; busy=0 the next cycle; no further ticks.
- Running at DIV=6, cfg_div=10 accepted at cnt=2 → current period keeps 6-cycle spacing, then spacing is 10; cfg_ready low from acceptance until the wrap.
- cfg_div=1 in IDLE → cfg_err pulses once; a subsequent start still gives period 6.
- start and stop together in IDLE → stays IDLE. stop asserted at cnt=3 in RUN → clk_flag stays 0, busy=0 next cycle, no done.
- sys_rst_n asserted mid-burst after DIV=4 was configured → all outputs 0 and cfg_ready=1 immediately; after release, start gives period 6 (DEFAULT_DIV).

Source files
------------

// File: rtl/div_tick_pkg.sv
// Shared types and defaults for the divided-tick controller.
package div_tick_pkg;

    localparam int unsigned DEF_CNT_W   = 8;
    localparam int unsigned DEF_BURST_W = 8;
    localparam int unsigned DEF_DIV     = 6;
    localparam int unsigned MIN_DIV     = 2;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } state_e;

endpackage

// File: rtl/div_tick_ctrl_if.sv
// Control, configuration and tick signals between system control and div_tick_ctrl.
interface div_tick_ctrl_if #(
    parameter int unsigned CNT_W   = div_tick_pkg::DEF_CNT_W,
    parameter int unsigned BURST_W = div_tick_pkg::DEF_BURST_W
) ();

    logic               start;
    logic               stop;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [CNT_W-1:0]   cfg_div;
    logic [BURST_W-1:0] cfg_burst;
    logic               cfg_err;
    logic               clk_flag;
    logic               busy;
    logic               done;

    modport master (
        output start, stop, cfg_valid, cfg_div, cfg_burst,
        input  cfg_ready, cfg_err, clk_flag, busy, done
    );

    modport slave (
        input  start, stop, cfg_valid, cfg_div, cfg_burst,
        output cfg_ready, cfg_err, clk_flag, busy, done
    );

endinterface

// File: rtl/div_tick_core.sv
// Divide counter with a registered tick, high while cnt == div-1.
module div_tick_core
    import div_tick_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] div,
    output logic             tick,
    output logic             tick_set
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] last_val;

    assign last_val = div - CNT_W'(1);
    assign cnt_d    = (cnt_q == last_val) ? '0 : cnt_q + CNT_W'(1);
    // Tick rises at the edge that loads the terminal count.
    assign tick_set = en && !clr && (cnt_d == last_val);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q <= '0;
            tick  <= 1'b0;
        end else if (clr) begin
            cnt_q <= '0;
            tick  <= 1'b0;
        end else if (en) begin
            cnt_q <= cnt_d;
            tick  <= tick_set;
        end
    end

endmodule

// File: rtl/div_tick_ctrl.sv
// Start/stop, configuration handshake and burst control around div_tick_core.
module div_tick_ctrl
    import div_tick_pkg::*;
#(
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned BURST_W     = DEF_BURST_W,
    parameter int unsigned DEFAULT_DIV = DEF_DIV
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    div_tick_ctrl_if.slave  bus
);

    state_e             state_q;
    logic [CNT_W-1:0]   div_q;
    logic [CNT_W-1:0]   pend_div_q;
    logic [BURST_W-1:0] burst_q;
    logic [BURST_W-1:0] pend_burst_q;
    logic [BURST_W-1:0] burst_cnt_q;
    logic               pend_q;
    logic               done_q;
    logic               err_q;

    logic tick;
    logic tick_set;
    logic run;
    logic accept;
    logic cfg_ok;
    logic wrap;
    logic to_idle;
    logic core_clr;
    logic burst_hit;

    assign run       = (state_q == StRun);
    assign accept    = bus.cfg_valid && !pend_q;
    assign cfg_ok    = (bus.cfg_div >= CNT_W'(MIN_DIV));
    // The tick cycle is the cycle with cnt == div-1, so its closing edge is the wrap.
    assign wrap      = run && tick;
    assign to_idle   = run && (bus.stop || done_q);
    assign core_clr  = !run || to_idle;
    assign burst_hit = (burst_q != '0) && (burst_cnt_q == burst_q - BURST_W'(1));

    div_tick_core #(
        .CNT_W (CNT_W)
    ) u_core (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .en        (run),
        .clr       (core_clr),
        .div       (div_q),
        .tick      (tick),
        .tick_set  (tick_set)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= StIdle;
            div_q        <= CNT_W'(DEFAULT_DIV);
            burst_q      <= '0;
            burst_cnt_q  <= '0;
            pend_q       <= 1'b0;
            pend_div_q   <= '0;
            pend_burst_q <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= accept && !cfg_ok;
            case (state_q)
                StIdle: begin
                    if (accept && cfg_ok) begin
                        div_q   <= bus.cfg_div;
                        burst_q <= bus.cfg_burst;
                    end
                    if (bus.start && !bus.stop) begin
                        state_q     <= StRun;
                        burst_cnt_q <= '0;
                    end
                end
                StRun: begin
                    if (to_idle) begin
                        state_q <= StIdle;
                        if (pend_q) begin
                            div_q   <= pend_div_q;
                            burst_q <= pend_burst_q;
                            pend_q  <= 1'b0;
                        end else if (accept && cfg_ok) begin
                            div_q   <= bus.cfg_div;
                            burst_q <= bus.cfg_burst;
                        end
                    end else begin
                        if (tick_set) begin
                            burst_cnt_q <= burst_cnt_q + BURST_W'(1);
                            done_q      <= burst_hit;
                        end
                        // Pending settings only land on a period boundary.
                        if (wrap && pend_q) begin
                            div_q       <= pend_div_q;
                            burst_q     <= pend_burst_q;
                            burst_cnt_q <= '0;
                            pend_q      <= 1'b0;
                        end else if (accept && cfg_ok) begin
                            pend_q       <= 1'b1;
                            pend_div_q   <= bus.cfg_div;
                            pend_burst_q <= bus.cfg_burst;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.cfg_ready = !pend_q;
    assign bus.cfg_err   = err_q;
    assign bus.clk_flag  = tick;
    assign bus.busy      = run;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_div_tick_ctrl.sv
// Scoreboard bench for div_tick_ctrl: expected tick/done/err cycles queued at stimulus time.
module tb_div_tick_ctrl;
    import div_tick_pkg::*;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;

    div_tick_ctrl_if #(.CNT_W(8), .BURST_W(8)) bus ();

    div_tick_ctrl #(
        .CNT_W       (8),
        .BURST_W     (8),
        .DEFAULT_DIV (6)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int exp_tick[$];
    int exp_done[$];
    int exp_err[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Wait for the negedge at which cyc == c (cyc counts rising edges so far).
    task automatic at_neg(input int c);
        @(negedge sys_clk);
        while (cyc < c) @(negedge sys_clk);
    endtask

    task automatic push_ticks(input int e, input int div, input int n);
        for (int k = 0; k < n; k++) exp_tick.push_back(e + div - 1 + k * div);
    endtask

    task automatic drain_check(input string tag);
        check_eq({tag, "_ticks_left"}, exp_tick.size(), 0);
        check_eq({tag, "_done_left"}, exp_done.size(), 0);
        check_eq({tag, "_err_left"}, exp_err.size(), 0);
        exp_tick.delete();
        exp_done.delete();
        exp_err.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_clk_flag"}, int'(bus.clk_flag), 0);
        check_eq({tag, "_busy"}, int'(bus.busy), 0);
        check_eq({tag, "_done"}, int'(bus.done), 0);
        check_eq({tag, "_cfg_err"}, int'(bus.cfg_err), 0);
        check_eq({tag, "_cfg_ready"}, int'(bus.cfg_ready), 1);
    endtask

    task automatic send_cfg(input int div, input int burst);
        bus.cfg_valid = 1'b1;
        bus.cfg_div   = 8'(div);
        bus.cfg_burst = 8'(burst);
    endtask

    always @(negedge sys_clk) begin
        if (bus.clk_flag) begin
            if (exp_tick.size() > 0) check_eq("tick_cycle", cyc, exp_tick.pop_front());
            else check_eq("tick_unexpected", int'(bus.clk_flag), 0);
        end
        if (bus.done) begin
            check_eq("done_with_tick", int'(bus.clk_flag), 1);
            if (exp_done.size() > 0) check_eq("done_cycle", cyc, exp_done.pop_front());
            else check_eq("done_unexpected", int'(bus.done), 0);
        end
        if (bus.cfg_err) begin
            if (exp_err.size() > 0) check_eq("err_cycle", cyc, exp_err.pop_front());
            else check_eq("err_unexpected", int'(bus.cfg_err), 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int e;
        int c;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_div   = '0;
        bus.cfg_burst = '0;

        at_neg(3);
        sys_rst_n = 1'b1;
        check_idle_outputs("reset");

        // Continuous run at the default ratio.
        at_neg(cyc + 2);
        bus.start = 1'b1;
        e = cyc + 1;
        push_ticks(e, 6, 3);
        at_neg(e);
        bus.start = 1'b0;
        check_eq("s1_busy", int'(bus.busy), 1);
        at_neg(e + 18);
        bus.stop = 1'b1;
        at_neg(e + 19);
        bus.stop = 1'b0;
        check_eq("s1_busy_after_stop", int'(bus.busy), 0);
        at_neg(e + 26);
        drain_check("s1");

        // start with stop in IDLE, then a rejected configuration.
        at_neg(cyc + 1);
        c = cyc;
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        at_neg(c + 1);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        check_eq("s4_stay_idle", int'(bus.busy), 0);
        check_eq("s4_ready", int'(bus.cfg_ready), 1);
        send_cfg(1, 5);
        exp_err.push_back(c + 2);
        at_neg(c + 2);
        bus.cfg_valid = 1'b0;
        at_neg(c + 4);
        bus.start = 1'b1;
        e = c + 5;
        push_ticks(e, 6, 2);
        at_neg(e);
        bus.start = 1'b0;
        at_neg(e + 12);
        bus.stop = 1'b1;
        at_neg(e + 13);
        bus.stop = 1'b0;
        at_neg(e + 20);
        drain_check("s4");

        // Burst of four ticks at ratio 3.
        at_neg(cyc + 1);
        send_cfg(3, 4);
        at_neg(cyc + 1);
        bus.cfg_valid = 1'b0;
        bus.start     = 1'b1;
        e = cyc + 1;
        push_ticks(e, 3, 4);
        exp_done.push_back(e + 11);
        at_neg(e);
        bus.start = 1'b0;
        at_neg(e + 11);
        check_eq("s2_busy_last_tick", int'(bus.busy), 1);
        at_neg(e + 12);
        check_eq("s2_busy_after_burst", int'(bus.busy), 0);
        at_neg(e + 20);
        drain_check("s2");

        // Ratio change in RUN lands at the wrap; then stop mid-period.
        at_neg(cyc + 1);
        send_cfg(6, 0);
        at_neg(cyc + 1);
        bus.cfg_valid = 1'b0;
        bus.start     = 1'b1;
        e = cyc + 1;
        exp_tick.push_back(e + 5);
        at_neg(e);
        bus.start = 1'b0;
        at_neg(e + 2);
        check_eq("s3_ready_before", int'(bus.cfg_ready), 1);
        send_cfg(10, 0);
        exp_tick.push_back(e + 15);
        exp_tick.push_back(e + 25);
        at_neg(e + 3);
        bus.cfg_valid = 1'b0;
        check_eq("s3_ready_pending", int'(bus.cfg_ready), 0);
        at_neg(e + 5);
        check_eq("s3_ready_tick", int'(bus.cfg_ready), 0);
        at_neg(e + 6);
        check_eq("s3_ready_after_wrap", int'(bus.cfg_ready), 1);
        at_neg(e + 29);
        bus.stop = 1'b1;
        at_neg(e + 30);
        bus.stop = 1'b0;
        check_eq("s3_busy_after_stop", int'(bus.busy), 0);
        at_neg(e + 40);
        drain_check("s3");

        // Reset in the middle of a burst at ratio 4.
        at_neg(cyc + 1);
        send_cfg(4, 5);
        at_neg(cyc + 1);
        bus.cfg_valid = 1'b0;
        bus.start     = 1'b1;
        e = cyc + 1;
        push_ticks(e, 4, 2);
        at_neg(e);
        bus.start = 1'b0;
        at_neg(e + 7);
        check_eq("s6_busy_before_rst", int'(bus.busy), 1);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check_idle_outputs("s6_rst");
        at_neg(e + 9);
        sys_rst_n = 1'b1;
        at_neg(e + 10);
        bus.start = 1'b1;
        e = cyc + 1;
        push_ticks(e, 6, 2);
        at_neg(e);
        bus.start = 1'b0;
        at_neg(e + 12);
        bus.stop = 1'b1;
        at_neg(e + 13);
        bus.stop = 1'b0;
        at_neg(e + 20);
        drain_check("s6");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
